// File: rtl/sprite_store.sv
// Multi-slot sprite pixel store: streaming valid/ready loader with per-slot length tracking.
// The draw engine reads through a registered read port. Optional macro: SPRITE_TRANSPARENT_EN.
module sprite_store #(
  parameter int         DATA_W            = 16,
  parameter int         DEPTH             = 800,
  parameter int         ADDR_W            = 10,
  parameter int         NUM_SPRITES       = 2,
  parameter int         SEL_W             = 1,
  parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [SEL_W-1:0]  load_sel,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_overflow,
  output logic              busy,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_oob,
  output logic              rd_transparent
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  slot;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len [NUM_SPRITES];
  logic [DATA_W-1:0] mem [NUM_SPRITES][DEPTH];

  logic start_ok, accept, at_end, last_word;

  assign start_ok  = load_start && ({1'b0, load_sel} < (SEL_W+1)'(NUM_SPRITES));
  assign accept    = load_valid && load_ready;
  assign at_end    = (wr_ptr == ADDR_W'(DEPTH-1));
  assign last_word = accept && (!load_data[0] || at_end);

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load control: the slot being (re)loaded reports length 0 until its final word lands
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      slot          <= '0;
      wr_ptr        <= '0;
      load_overflow <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) len[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_ok) begin
        slot          <= load_sel;
        wr_ptr        <= '0;
        load_overflow <= 1'b0;
        len[load_sel] <= '0;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!load_data[0]) begin
          len[slot] <= {1'b0, wr_ptr} + 1'b1;
        end else if (at_end) begin
          len[slot]     <= (ADDR_W+1)'(DEPTH);
          load_overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[slot][wr_ptr] <= load_data;
  end

  // Read stage 0: bounds check against the selected slot's length
  logic [ADDR_W:0]   sel_len;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if ({1'b0, rd_sel} == (SEL_W+1)'(i)) sel_len = len[i];
    end
    rd_in_range = ({1'b0, rd_addr} < sel_len);
    rd_word     = rd_in_range ? mem[rd_sel][rd_addr] : '0;
  end

  // Read stage 1: registered outputs; data holds when no read is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_oob   <= rd_en && !rd_in_range;
      if (rd_en) rd_data <= rd_word;
    end
  end

`ifdef SPRITE_TRANSPARENT_EN
  always_ff @(posedge clk) begin
    if (reset) rd_transparent <= 1'b0;
    else       rd_transparent <= rd_en && rd_in_range && (rd_word[3:1] == TRANSPARENT_COLOR);
  end
`else
  logic unused_transparent;
  assign unused_transparent = ^TRANSPARENT_COLOR;
  assign rd_transparent     = 1'b0;
`endif

endmodule

// File: doc/sprite_store.md
Name: sprite_store

Overview:
- Multi-slot sprite pixel store for the VGA sprite path.
- A streaming loader writes packed pixel words into one of NUM_SPRITES slots. Loading for a slot ends on the word whose stop bit is 0, or when the slot is full.
- The draw engine reads any loaded slot through a registered read port with 1-cycle latency.
- Generalises the single fixed 800-entry sprite RAM: parametrised width, depth and slot count; valid/ready load handshake; per-slot length tracking; out-of-range read protection.

Parameters:
- DATA_W, 16, pixel word width; layout {x[15:10], y[9:4], color[3:1], stop[0]}
- DEPTH, 800, words per slot
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH
- NUM_SPRITES, 2, number of slots
- SEL_W, 1, slot select width; must satisfy 2^SEL_W >= NUM_SPRITES
- TRANSPARENT_COLOR, 3'b000, color code reported as transparent (optional feature only)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- load_start  in  1  1-cycle pulse; begins a load into slot load_sel
- load_sel  in  SEL_W  target slot; sampled on the accepted load_start
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  pixel word to store
- load_ready  out  1  store accepts load_data this cycle
- load_done  out  1  1-cycle pulse when a load completes
- load_overflow  out  1  sticky; the last load hit DEPTH without a stop=0 word
- busy  out  1  high while in LOAD
- rd_en  in  1  read request
- rd_sel  in  SEL_W  slot to read
- rd_addr  in  ADDR_W  word index within the slot
- rd_valid  out  1  rd_data valid; follows rd_en by 1 cycle
- rd_data  out  DATA_W  read word; 0 if out of range
- rd_oob  out  1  qualifies rd_valid; read was out of range
- rd_transparent  out  1  qualifies rd_valid; see Optional Feature

Behaviour:
- Reset values: load_ready=0, load_done=0, load_overflow=0, busy=0, rd_valid=0, rd_data=0, rd_oob=0, rd_transparent=0.
- Reset clears every slot length to 0 and forces IDLE. Memory contents are not cleared.
- State machine states: IDLE, LOAD, DONE.
- IDLE:
  - load_ready=0.
  - load_start=1 latches the slot from load_sel, sets wr_ptr=0, clears load_overflow and the latched slot's length, then goes to LOAD.
  - load_sel >= NUM_SPRITES: load_start is ignored.
- LOAD:
  - load_ready=1 and busy=1.
  - A word is accepted when load_valid && load_ready; it is written at slot[wr_ptr] and wr_ptr increments.
  - Accepted word with stop bit 0: length = wr_ptr+1, go to DONE.
  - Accepted word at wr_ptr == DEPTH-1 with stop bit 1: length = DEPTH, set load_overflow, go to DONE.
  - load_start while in LOAD is ignored.
- DONE: load_done=1 for exactly one cycle, load_ready=0, then return to IDLE.
- Load throughput: 1 word per cycle.
- A load on an already-loaded slot overwrites it. Its length reads as 0 from load_start until the load completes.
- Read port:
  - rd_en is sampled at cycle N; rd_valid, rd_data, rd_oob and rd_transparent are registered and appear at cycle N+1.
  - Reads are fully pipelined, one per cycle.
  - Out of range when rd_sel >= NUM_SPRITES or rd_addr >= length[rd_sel]: rd_data=0, rd_oob=1.
  - rd_en=0: rd_valid=0 next cycle, and rd_data holds its previous value.
- Simultaneous read and write:
  - A read of the slot being loaded returns rd_oob=1 (its length is 0 during the load).
  - A read of any other slot completes normally in the same cycle as a write.
- Reset mid-load: the load is aborted, load_done is not pulsed, and all lengths become 0.

Optional Feature:
- Macro SPRITE_TRANSPARENT_EN.
- Defined: rd_transparent=1 on a valid, in-range read whose color field rd_data[3:1] equals TRANSPARENT_COLOR. rd_data is returned unchanged.
- Not defined: rd_transparent is tied to 0, and TRANSPARENT_COLOR is unused.

Test Plan:
- Basic load and read: reset; load_start with load_sel=0; stream 5 words, stop=1 on the first four and the fifth = 16'h0A52 (stop=0) -> load_done pulses on the cycle after the 5th accept. Then rd_en with rd_sel=0, rd_addr=4 -> next cycle rd_valid=1, rd_data=16'h0A52, rd_oob=0.
- Bounds: after the basic load, read rd_addr=5 -> rd_oob=1, rd_data=0. Read rd_sel=1 (never loaded) at rd_addr=0 -> rd_oob=1.
- Overflow, using DEPTH=8: stream 8 words, all with stop=1 -> load_done pulses and load_overflow=1; read rd_addr=7 returns word 7 with rd_oob=0.
- Backpressure and ignored start: toggle load_valid 1,0,1,0 with 3 words (last stop=0) and pulse load_start mid-load -> exactly 3 words stored, no restart, busy=1 throughout LOAD.
- Concurrency and reset: load slot 1 while reading slot 0 every cycle -> slot 0 data correct with 1-cycle latency, slot 1 reads rd_oob=1 until load_done. Assert reset mid-load of slot 0 -> no load_done; both slots then read rd_oob=1.
- Transparency: with SPRITE_TRANSPARENT_EN defined, read a word with color=3'b000 -> rd_transparent=1; color=3'b101 -> rd_transparent=0. Without the macro, rd_transparent stays 0.
